// File: rtl/ram_load_assembler.sv
// Byte-serial big-endian load assembler: n = 1/2/4/8 RAM reads, result right-aligned in a quad word.
// Optional sign extension of sub-quad loads is enabled by defining RAM_LOAD_SIGN_EXT_EN.
package pkg_ram;
    localparam int RAM_QUAD_SIZE = 64;
    typedef enum logic [1:0] {
        RAM_BYTE = 2'd0,
        RAM_WORD = 2'd1,
        RAM_LONG = 2'd2,
        RAM_QUAD = 2'd3
    } data_type_t;
endpackage

module ram_load_assembler
    import pkg_ram::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  data_type_t               req_type,
`ifdef RAM_LOAD_SIGN_EXT_EN
    input  logic                     req_signed,
`endif
    output logic                     ram_rd_en,
    output logic [ADDR_W-1:0]        ram_addr,
    input  logic [7:0]               ram_rdata,
    output logic                     data_valid,
    output logic [RAM_QUAD_SIZE-1:0] data_out,
    output logic                     misaligned
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                   state, state_nxt;
    logic [ADDR_W-1:0]        base;
    logic [3:0]               n, n_req, issue_cnt;
    logic                     sgn;
    logic                     rd_d;
    logic                     aligned_req;
    logic [RAM_QUAD_SIZE-1:0] acc, acc_shift;

    always_comb begin
        case (req_type)
            RAM_BYTE: n_req = 4'd1;
            RAM_WORD: n_req = 4'd2;
            RAM_LONG: n_req = 4'd4;
            default:  n_req = 4'd8;
        endcase
    end

    assign aligned_req = ((req_addr & ADDR_W'(n_req - 4'd1)) == '0);
    assign req_ready   = (state == IDLE);
    assign acc_shift   = {acc[RAM_QUAD_SIZE-9:0], ram_rdata};

    function automatic logic [RAM_QUAD_SIZE-1:0] extend(input logic [RAM_QUAD_SIZE-1:0] v,
                                                        input logic [3:0] cnt, input logic s);
        logic [RAM_QUAD_SIZE-1:0] r;
        r = v;
        case (cnt)
            4'd1:    r = {{56{s & v[7]}},  v[7:0]};
            4'd2:    r = {{48{s & v[15]}}, v[15:0]};
            4'd4:    r = {{32{s & v[31]}}, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = aligned_req ? FETCH : DONE;
            FETCH:   if (issue_cnt == n) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // rd_d marks the cycle in which ram_rdata carries the byte requested one cycle earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base       <= '0;
            n          <= 4'd0;
            issue_cnt  <= 4'd0;
            rd_d       <= 1'b0;
            acc        <= '0;
            ram_rd_en  <= 1'b0;
            ram_addr   <= '0;
            data_valid <= 1'b0;
            data_out   <= '0;
            misaligned <= 1'b0;
        end else begin
            rd_d       <= ram_rd_en;
            data_valid <= 1'b0;
            if (rd_d) acc <= acc_shift;
            case (state)
                IDLE: if (req_valid) begin
                    base      <= req_addr;
                    n         <= n_req;
                    acc       <= '0;
                    issue_cnt <= 4'd1;
                    if (aligned_req) begin
                        ram_rd_en <= 1'b1;
                        ram_addr  <= req_addr;
                    end else begin
                        data_valid <= 1'b1;
                        misaligned <= 1'b1;
                        data_out   <= '0;
                    end
                end
                FETCH: begin
                    if (issue_cnt == n) begin
                        ram_rd_en <= 1'b0;
                    end else begin
                        ram_addr  <= base + ADDR_W'(issue_cnt);
                        issue_cnt <= issue_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    data_valid <= 1'b1;
                    misaligned <= 1'b0;
                    data_out   <= extend(acc_shift, n, sgn);
                end
                default: ;
            endcase
        end
    end

`ifdef RAM_LOAD_SIGN_EXT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          sgn <= 1'b0;
        else if (state == IDLE && req_valid) sgn <= req_signed;
    end
`else
    assign sgn = 1'b0;
`endif

endmodule
